// File: rtl/gate_alu_pipe.sv
// gate_alu_pipe
//   Two-stage valid/ready pipeline around a bitwise logic unit with an
//   optional accumulator operand.
//   Stage 1 registers the request. Stage 2 computes the result and registers it
//   together with its zero and parity flags.
//
// Ports
//   clk          : clock, rising edge
//   rst          : asynchronous active-high reset
//   i_in_valid   : upstream request valid (i_a, i_b, i_op, i_acc_en)
//   o_in_ready   : request accepted on this edge when i_in_valid is also set
//   i_a, i_b     : operands (i_a is ignored when i_acc_en=1)
//   i_op         : 0 AND, 1 OR, 2 NOT A, 3 NAND, 4 NOR, 5 XOR, 6 XNOR, 7 PASS B
//   i_acc_en     : use the accumulator as operand A and write y back to it
//   o_out_valid  : result valid
//   i_out_ready  : downstream accepts the result
//   o_y          : bitwise result
//   o_zero       : o_y is all zeros
//   o_parity     : XOR-reduction of o_y
//   o_tx_count   : saturating count of completed output handshakes
module gate_alu_pipe #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_in_valid,
  output logic             o_in_ready,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic [2:0]       i_op,
  input  logic             i_acc_en,
  output logic             o_out_valid,
  input  logic             i_out_ready,
  output logic [WIDTH-1:0] o_y,
  output logic             o_zero,
  output logic             o_parity,
  output logic [CNT_W-1:0] o_tx_count
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic             r_s1_v;
  logic [WIDTH-1:0] r_s1_a;
  logic [WIDTH-1:0] r_s1_b;
  logic [2:0]       r_s1_op;
  logic             r_s1_acc;

  logic             r_out_valid;
  logic [WIDTH-1:0] r_y;
  logic             r_zero;
  logic             r_parity;
  logic [WIDTH-1:0] r_acc;
  logic [CNT_W-1:0] r_tx_count;

  logic             w_s2_load;
  logic             w_in_xfer;
  logic             w_out_xfer;
  logic [WIDTH-1:0] w_opa;
  logic [WIDTH-1:0] w_res;

  // Stage 2 takes the stage 1 item whenever its own slot is empty or draining.
  // There is no skid buffer, so stage 1 can only accept while it is empty or
  // is being emptied into stage 2 on this very edge.
  assign w_s2_load  = r_s1_v && (!r_out_valid || i_out_ready);
  assign o_in_ready = !rst && (!r_s1_v || w_s2_load);
  assign w_in_xfer  = i_in_valid && o_in_ready;
  assign w_out_xfer = r_out_valid && i_out_ready;

  // The accumulator is read when stage 2 loads the item, not when stage 1
  // accepts it. Items load in order, so acc_en items chain correctly even
  // when they are back-to-back.
  always_comb begin
    w_opa = r_s1_acc ? r_acc : r_s1_a;
    w_res = '0;
    case (r_s1_op)
      3'd0:    w_res = w_opa & r_s1_b;
      3'd1:    w_res = w_opa | r_s1_b;
      3'd2:    w_res = ~w_opa;
      3'd3:    w_res = ~(w_opa & r_s1_b);
      3'd4:    w_res = ~(w_opa | r_s1_b);
      3'd5:    w_res = w_opa ^ r_s1_b;
      3'd6:    w_res = ~(w_opa ^ r_s1_b);
      default: w_res = r_s1_b;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_v   <= 1'b0;
      r_s1_a   <= '0;
      r_s1_b   <= '0;
      r_s1_op  <= '0;
      r_s1_acc <= 1'b0;
    end else if (w_in_xfer) begin
      r_s1_v   <= 1'b1;
      r_s1_a   <= i_a;
      r_s1_b   <= i_b;
      r_s1_op  <= i_op;
      r_s1_acc <= i_acc_en;
    end else if (w_s2_load) begin
      r_s1_v <= 1'b0;
    end
  end

  // A load on the same edge as an output transfer replaces the outgoing
  // result directly, so full-rate streaming has no bubbles. Otherwise the
  // result and its flags hold until the next load.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_y         <= '0;
      r_zero      <= 1'b0;
      r_parity    <= 1'b0;
      r_acc       <= '0;
    end else if (w_s2_load) begin
      r_out_valid <= 1'b1;
      r_y         <= w_res;
      r_zero      <= (w_res == '0);
      r_parity    <= ^w_res;
      if (r_s1_acc) begin
        r_acc <= w_res;
      end
    end else if (w_out_xfer) begin
      r_out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tx_count <= '0;
    end else if (w_out_xfer && (r_tx_count != CNT_MAX)) begin
      r_tx_count <= r_tx_count + 1'b1;
    end
  end

  assign o_out_valid = r_out_valid;
  assign o_y         = r_y;
  assign o_zero      = r_zero;
  assign o_parity    = r_parity;
  assign o_tx_count  = r_tx_count;

endmodule

// File: tb/tb_gate_alu_pipe.sv
// tb_gate_alu_pipe
//   Bench for gate_alu_pipe at WIDTH=8. A small counter width is used so that
//   tx_count saturation is reached.
//   Inputs are driven 1 ns after the rising edge. All outputs are sampled on
//   the falling edge.
module tb_gate_alu_pipe;

  localparam int WIDTH = 8;
  localparam int CNT_W = 4;
  localparam logic [CNT_W-1:0] TX_MAX = 4'hF;

  logic             clk;
  logic             rst;
  logic             inValid;
  logic             inReady;
  logic [WIDTH-1:0] opA;
  logic [WIDTH-1:0] opB;
  logic [2:0]       opSel;
  logic             accEn;
  logic             outValid;
  logic             outReady;
  logic [WIDTH-1:0] yOut;
  logic             zeroOut;
  logic             parityOut;
  logic [CNT_W-1:0] txCount;

  int checks = 0;
  int errors = 0;

  gate_alu_pipe #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .i_in_valid  (inValid),
    .o_in_ready  (inReady),
    .i_a         (opA),
    .i_b         (opB),
    .i_op        (opSel),
    .i_acc_en    (accEn),
    .o_out_valid (outValid),
    .i_out_ready (outReady),
    .o_y         (yOut),
    .o_zero      (zeroOut),
    .o_parity    (parityOut),
    .o_tx_count  (txCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkValue(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference behaviour for one operation, straight from the function table.
  function automatic logic [WIDTH-1:0] refAlu(input logic [2:0] op, input logic [WIDTH-1:0] a,
                                              input logic [WIDTH-1:0] b);
    case (op)
      3'd0:    return a & b;
      3'd1:    return a | b;
      3'd2:    return ~a;
      3'd3:    return ~(a & b);
      3'd4:    return ~(a | b);
      3'd5:    return a ^ b;
      3'd6:    return ~(a ^ b);
      default: return b;
    endcase
  endfunction

  typedef struct packed {
    logic [WIDTH-1:0] y;
    logic             zero;
    logic             par;
  } result_t;

  result_t          expQ[$];
  logic [WIDTH-1:0] modelAcc = '0;
  logic [CNT_W-1:0] modelTx = '0;
  logic             prevStall = 1'b0;
  logic [WIDTH-1:0] prevY = '0;

  // Scoreboard: each accepted item is predicted in acceptance order. Every
  // output handshake must match the oldest prediction.
  always @(negedge clk) begin
    if (rst) begin
      expQ.delete();
      modelAcc  = '0;
      modelTx   = '0;
      prevStall = 1'b0;
    end else begin
      result_t r;
      logic [WIDTH-1:0] a;
      checkValue("sb_tx_count", txCount, modelTx);
      if (prevStall) begin
        checkValue("sb_stall_valid", outValid, 1);
        checkValue("sb_stall_hold_y", yOut, prevY);
      end
      if (outValid && outReady) begin
        if (expQ.size() == 0) begin
          checkValue("sb_unexpected_output", 1, 0);
        end else begin
          r = expQ.pop_front();
          checkValue("sb_y", yOut, r.y);
          checkValue("sb_zero", zeroOut, r.zero);
          checkValue("sb_parity", parityOut, r.par);
        end
        if (modelTx != TX_MAX) modelTx = modelTx + 1'b1;
      end
      if (inValid && inReady) begin
        a = accEn ? modelAcc : opA;
        r.y = refAlu(opSel, a, opB);
        r.zero = (r.y == 0);
        r.par = ($countones(r.y) % 2) == 1;
        if (accEn) modelAcc = r.y;
        expQ.push_back(r);
      end
      prevStall = outValid && !outReady;
      prevY = yOut;
    end
  end

  // Offer one item and hold it until it is accepted.
  task automatic applyStimulus(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                               input logic acc);
    bit got = 0;
    inValid = 1'b1;
    opSel = op;
    opA = a;
    opB = b;
    accEn = acc;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (inReady) begin
        got = 1;
        break;
      end
    end
    if (!got) checkValue("accept_timeout", 0, 1);
    @(posedge clk);
    #1;
    inValid = 1'b0;
  endtask

  // Wait for the next result (out_ready assumed high) and compare it.
  task automatic checkOutput(input string name, input logic [7:0] y, input logic z, input logic p);
    bit got = 0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (outValid) begin
        got = 1;
        break;
      end
    end
    if (!got) begin
      checkValue({name, "_timeout"}, 0, 1);
    end else begin
      checkValue({name, "_y"}, yOut, y);
      checkValue({name, "_zero"}, zeroOut, z);
      checkValue({name, "_parity"}, parityOut, p);
    end
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [2:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic       acc;
    logic [7:0] y;
    logic       zero;
    logic       par;
  } vec_t;

  vec_t vecs[13];

  initial begin
    vecs[0]  = '{3'd0, 8'hF0, 8'h3C, 1'b0, 8'h30, 1'b0, 1'b0};
    vecs[1]  = '{3'd1, 8'h00, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0};
    vecs[2]  = '{3'd2, 8'h0F, 8'hFF, 1'b0, 8'hF0, 1'b0, 1'b0};
    vecs[3]  = '{3'd3, 8'hFF, 8'h01, 1'b0, 8'hFE, 1'b0, 1'b1};
    vecs[4]  = '{3'd4, 8'h80, 8'h01, 1'b0, 8'h7E, 1'b0, 1'b0};
    vecs[5]  = '{3'd5, 8'h12, 8'h34, 1'b0, 8'h26, 1'b0, 1'b1};
    vecs[6]  = '{3'd6, 8'h12, 8'h34, 1'b0, 8'hD9, 1'b0, 1'b1};
    vecs[7]  = '{3'd7, 8'hFF, 8'h81, 1'b0, 8'h81, 1'b0, 1'b0};
    vecs[8]  = '{3'd7, 8'hAA, 8'h0F, 1'b1, 8'h0F, 1'b0, 1'b0};
    vecs[9]  = '{3'd5, 8'h00, 8'hFF, 1'b1, 8'hF0, 1'b0, 1'b0};
    vecs[10] = '{3'd1, 8'h01, 8'h02, 1'b0, 8'h03, 1'b0, 1'b0};
    vecs[11] = '{3'd0, 8'hFF, 8'h3C, 1'b1, 8'h30, 1'b0, 1'b0};
    vecs[12] = '{3'd6, 8'h00, 8'h30, 1'b1, 8'hFF, 1'b0, 1'b0};

    rst = 1'b1;
    inValid = 1'b0;
    outReady = 1'b1;
    opA = '0;
    opB = '0;
    opSel = '0;
    accEn = 1'b0;

    repeat (2) @(negedge clk);
    checkValue("rst_in_ready", inReady, 0);
    checkValue("rst_out_valid", outValid, 0);
    checkValue("rst_zero", zeroOut, 0);
    @(posedge clk);
    #1 rst = 1'b0;

    // State right after reset release.
    @(negedge clk);
    checkValue("rel_out_valid", outValid, 0);
    checkValue("rel_y", yOut, 8'h00);
    checkValue("rel_zero", zeroOut, 0);
    checkValue("rel_tx_count", txCount, 0);
    checkValue("rel_in_ready", inReady, 1);

    // Two-cycle latency for AND F0 & 3C.
    @(posedge clk);
    #1;
    inValid = 1'b1; opSel = 3'd0; opA = 8'hF0; opB = 8'h3C; accEn = 1'b0;
    @(negedge clk);
    checkValue("lat_in_ready", inReady, 1);
    @(posedge clk);
    #1 inValid = 1'b0;
    @(negedge clk);
    checkValue("lat_not_yet_valid", outValid, 0);
    @(negedge clk);
    checkValue("lat_out_valid", outValid, 1);
    checkValue("lat_y", yOut, 8'h30);
    checkValue("lat_zero", zeroOut, 0);
    checkValue("lat_parity", parityOut, 0);
    @(negedge clk);
    checkValue("lat_tx_count", txCount, 1);
    checkValue("lat_drained", outValid, 0);

    // Back-to-back XOR then NAND.
    @(posedge clk);
    #1;
    inValid = 1'b1; opSel = 3'd5; opA = 8'hAA; opB = 8'hAA;
    @(posedge clk);
    #1;
    opSel = 3'd3; opA = 8'h0F; opB = 8'hFF;
    @(negedge clk);
    checkValue("b2b_in_ready", inReady, 1);
    @(posedge clk);
    #1 inValid = 1'b0;
    @(negedge clk);
    checkValue("b2b_first_valid", outValid, 1);
    checkValue("b2b_first_y", yOut, 8'h00);
    checkValue("b2b_first_zero", zeroOut, 1);
    @(negedge clk);
    checkValue("b2b_second_valid", outValid, 1);
    checkValue("b2b_second_y", yOut, 8'hF0);
    checkValue("b2b_second_parity", parityOut, 0);
    @(posedge clk);
    #1;

    // Table of single items, including an accumulator chain with a
    // non-accumulator item in the middle.
    for (int i = 0; i < 13; i++) begin
      applyStimulus(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].acc);
      checkOutput($sformatf("vec%0d", i), vecs[i].y, vecs[i].zero, vecs[i].par);
    end

    // Backpressure: three items offered with out_ready low.
    outReady = 1'b0;
    inValid = 1'b1; opSel = 3'd1; opA = 8'h01; opB = 8'h02; accEn = 1'b0;
    @(negedge clk);
    checkValue("bp_accept1", inReady, 1);
    @(posedge clk);
    #1 opSel = 3'd4; opA = 8'h00; opB = 8'h0F;
    @(negedge clk);
    checkValue("bp_accept2", inReady, 1);
    @(posedge clk);
    #1 opSel = 3'd2; opA = 8'h5A; opB = 8'h00;
    @(negedge clk);
    checkValue("bp_block3", inReady, 0);
    @(posedge clk);
    #1;
    @(negedge clk);
    checkValue("bp_still_blocked", inReady, 0);
    checkValue("bp_held_y", yOut, 8'h03);
    @(posedge clk);
    #1 outReady = 1'b1;
    @(negedge clk);
    checkValue("bp_release_ready", inReady, 1);
    checkValue("bp_out1_valid", outValid, 1);
    checkValue("bp_out1_y", yOut, 8'h03);
    @(posedge clk);
    #1 inValid = 1'b0;
    @(negedge clk);
    checkValue("bp_out2_valid", outValid, 1);
    checkValue("bp_out2_y", yOut, 8'hF0);
    @(negedge clk);
    checkValue("bp_out3_valid", outValid, 1);
    checkValue("bp_out3_y", yOut, 8'hA5);
    @(negedge clk);
    checkValue("bp_empty", outValid, 0);

    // Reset with both stages full; the accumulator was AA before reset.
    @(posedge clk);
    #1;
    outReady = 1'b0;
    inValid = 1'b1; opSel = 3'd7; opA = 8'h00; opB = 8'hAA; accEn = 1'b1;
    @(posedge clk);
    #1 opSel = 3'd1; opB = 8'h11; accEn = 1'b0;
    @(posedge clk);
    #1 inValid = 1'b0;
    @(negedge clk);
    checkValue("full_out_valid", outValid, 1);
    checkValue("full_in_ready", inReady, 0);
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    checkValue("mid_rst_out_valid", outValid, 0);
    checkValue("mid_rst_y", yOut, 8'h00);
    checkValue("mid_rst_zero", zeroOut, 0);
    checkValue("mid_rst_parity", parityOut, 0);
    checkValue("mid_rst_tx_count", txCount, 0);
    checkValue("mid_rst_in_ready", inReady, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    outReady = 1'b1;
    @(negedge clk);
    checkValue("post_rst_in_ready", inReady, 1);
    for (int n = 0; n < 4; n++) begin
      if (n > 0) @(negedge clk);
      checkValue("post_rst_no_stale", outValid, 0);
    end
    @(posedge clk);
    #1;
    applyStimulus(3'd5, 8'hFF, 8'h55, 1'b1);
    checkOutput("acc_after_rst", 8'h55, 1'b0, 1'b0);

    // Random traffic against the scoreboard.
    for (int n = 0; n < 600; n++) begin
      inValid  = ($urandom_range(0, 9) < 7);
      outReady = ($urandom_range(0, 9) < 6);
      opSel    = 3'($urandom_range(0, 7));
      opA      = 8'($urandom);
      opB      = 8'($urandom);
      accEn    = ($urandom_range(0, 2) == 0);
      @(posedge clk);
      #1;
    end
    inValid = 1'b0;
    outReady = 1'b1;
    repeat (10) @(posedge clk);
    @(negedge clk);
    checkValue("drain_queue_empty", expQ.size(), 0);
    checkValue("drain_out_valid", outValid, 0);
    checkValue("tx_count_saturated", txCount, TX_MAX);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/gate_alu_pipe.md
GATE_ALU_PIPE -- requirements
Module: gate_alu_pipe

Interface
REQ-001 Parameter WIDTH, default 8, operand and result width in bits (legal range 1..64).
REQ-002 Parameter CNT_W, default 16, width of the completed-transaction counter.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 in_valid  input  1  upstream presents a, b, op and acc_en.
REQ-006 in_ready  output  1  block accepts input this cycle.
REQ-007 a  input  WIDTH  operand A, ignored when acc_en=1.
REQ-008 b  input  WIDTH  operand B.
REQ-009 op  input  3  function select: 0 AND, 1 OR, 2 NOT A, 3 NAND, 4 NOR, 5 XOR, 6 XNOR, 7 PASS B.
REQ-010 acc_en  input  1  use the accumulator as operand A and write the result back to it.
REQ-011 out_valid  output  1  result valid.
REQ-012 out_ready  input  1  downstream accepts the result.
REQ-013 y  output  WIDTH  bitwise result.
REQ-014 zero  output  1  y is all zeros.
REQ-015 parity  output  1  XOR-reduction of y.
REQ-016 tx_count  output  CNT_W  count of completed output handshakes, saturating.

Function
REQ-017 An input transfer occurs on a rising edge where in_valid=1 and in_ready=1; an output transfer occurs on a rising edge where out_valid=1 and out_ready=1.
REQ-018 Stage 1 shall register a, b, op and acc_en together with a valid bit s1_v; stage 2 shall compute the function and register y, zero, parity and out_valid.
REQ-019 Stage 2 shall load on any edge where s1_v=1 and (out_valid=0 or out_ready=1); s1_v shall clear on that edge unless a new input transfer occurs on the same edge.
REQ-020 in_ready shall equal (s1_v=0) or (stage 2 loads this cycle), computed combinationally; there is no skid buffer.
REQ-021 Latency shall be 2 cycles with no backpressure: an input accepted at edge T gives out_valid=1 after edge T+1.
REQ-022 Sustained throughput shall be one transfer per clock when out_ready=1.
REQ-023 All functions shall be bitwise over WIDTH bits; NOT A ignores b; PASS B ignores operand A.
REQ-024 When stage 2 loads an item with acc_en=1, operand A shall be the current accumulator value, and the accumulator shall take the new y on that same edge.
REQ-025 Consecutive acc_en items shall chain: each item uses the result of the previous acc_en item, regardless of any non-acc items between them.
REQ-026 An item with acc_en=0 shall not modify the accumulator.
REQ-027 op=7 with acc_en=1 shall load the accumulator with b; this is the only accumulator preload path.
REQ-028 y, zero and parity shall hold their values while out_valid=1 and out_ready=0.
REQ-029 When out_valid=0, y, zero and parity shall hold their last values.
REQ-030 tx_count shall increment by 1 on each output transfer and hold at 2^CNT_W-1 once reached.
REQ-031 Simultaneous output transfer and stage 2 load shall replace the outgoing result with the new one with no bubble.
REQ-032 Items shall leave the block in acceptance order; none shall be dropped or duplicated.

Reset
REQ-033 When rst=1, the block shall immediately clear s1_v, out_valid, y, zero, parity, the accumulator and tx_count to 0; zero is forced to 0 while in reset.
REQ-034 in_ready shall be 0 while rst=1 and 1 in the first cycle after rst deasserts.
REQ-035 Reset mid-operation shall discard all in-flight items, and no out_valid pulse shall follow for them.

Verification (WIDTH=8)
REQ-036 Release reset -> out_valid=0, y=0x00, zero=0, tx_count=0, in_ready=1.
REQ-037 AND, a=0xF0, b=0x3C, out_ready=1 -> out_valid after 2 cycles, y=0x30, zero=0, parity=0, tx_count=1.
REQ-038 XOR, a=0xAA, b=0xAA, then NAND, a=0x0F, b=0xFF, back-to-back -> y=0x00 with zero=1, then y=0xF0 with parity=0, on consecutive cycles.
REQ-039 out_ready=0 with 3 items offered -> 2 accepted, then in_ready=0 with the third held; raise out_ready -> all 3 out in order, no gaps.
REQ-040 acc_en=1 sequence PASS B b=0x0F, XOR b=0xFF, AND b=0x3C -> y=0x0F, 0xF0, 0x30, with the accumulator ending at 0x30.
REQ-041 Assert rst with both stages full -> out_valid=0 immediately; no stale output after reset; the accumulator reads 0 on the next acc_en XOR with b=0x55, giving y=0x55.
